// File: rtl/rs_sched_pkg.sv
// rs_sched_pkg: shared types and constants for the reservation station.
//   - t_prf_id / t_rob_id   : physical register and ROB identifiers
//   - t_disp_pkt            : dispatched uop (uinstr, robid, rename, meta)
//   - t_nuke_pkt            : pipeline flush request
//   - t_rs_entry / t_rs_id  : one buffered RS slot and its index type
//   - get_psrc()            : source-operand selector used by the wakeup logic
package rs_sched_pkg;

  localparam int NUM_SOURCES        = 2;
  localparam int NUM_RS_ENTRIES_DEF = 8;

  typedef logic [6:0] t_prf_id;
  typedef logic [5:0] t_rob_id;
  typedef logic [$clog2(NUM_RS_ENTRIES_DEF)-1:0] t_rs_id;

  typedef struct packed {
    t_prf_id pdst;
    t_prf_id psrc1;
    t_prf_id psrc2;
  } t_rename;

  typedef struct packed {
    logic [15:0] uinstr;
    t_rob_id     robid;
    t_rename     rename;
    logic [3:0]  meta;
  } t_disp_pkt;

  typedef struct packed {
    logic valid;
  } t_nuke_pkt;

  typedef struct packed {
    logic                   valid;
    t_disp_pkt              pkt;
    logic [NUM_SOURCES-1:0] src_rdy;
  } t_rs_entry;

  // Source index 0 is psrc1, index 1 is psrc2; matches src_rdy bit order.
  function automatic t_prf_id get_psrc(input t_disp_pkt pkt, input int s);
    return (s == 0) ? pkt.rename.psrc1 : pkt.rename.psrc2;
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// rs_age_matrix: relative-age tracker for the reservation station slots.
//   clk, reset_n : clock, synchronous active-low reset
//   flush        : discard all age information
//   alloc        : one-hot slot being written this cycle (becomes youngest)
//   dealloc      : one-hot slot being freed this cycle
//   req          : slots requesting selection
//   oldest       : one-hot of the requesting slot with no older requester
module rs_age_matrix
  import rs_sched_pkg::*;
#(
  parameter int N = NUM_RS_ENTRIES_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic [N-1:0] alloc,
  input  logic [N-1:0] dealloc,
  input  logic [N-1:0] req,
  output logic [N-1:0] oldest
);

  // older_q[i][j] set means slot j is older than slot i. Bits pointing at free
  // slots may be stale; they are harmless because req only covers live slots,
  // and the column is cleared whenever that slot is reallocated.
  logic [N-1:0] older_q [N];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!reset_n || flush) begin
          older_q[i][j] <= 1'b0;
        end else if (alloc[i]) begin
          // New slot is younger than every other slot still live next cycle.
          older_q[i][j] <= (i != j) && !dealloc[j];
        end else if (alloc[j] || dealloc[j]) begin
          older_q[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      oldest[i] = req[i] && !(|(req & older_q[i]));
    end
  end

endmodule

// File: rtl/rs_sched.sv
// rs_sched: reservation station between dispatch and the execute pipe.
// Buffers dispatched uops, wakes sources on writeback broadcasts and issues the
// oldest fully-ready uop over a valid/ready handshake. A nuke flushes all slots.
//   clk, reset_n                 : clock, synchronous active-low reset
//   nuke_rb1                     : flush request (.valid)
//   disp_valid_rs0/disp_pkt_rs0  : dispatch; src_rdy_rs0 gives scoreboard readiness
//   rs_stall_rs0                 : no free slot (registered state only)
//   wb_valid_rs0/wb_pdst_rs0     : writeback wakeup broadcasts
//   iss_valid_rs1/iss_pkt_rs1    : issue, accepted when ex_ready_rs1 is high
// Optional macro RS_PERF_EN adds perf_occ_rs (live occupancy) and
// perf_stall_cyc (saturating count of stalled cycles).
module rs_sched
  import rs_sched_pkg::*;
#(
  parameter int NUM_RS_ENTRIES = NUM_RS_ENTRIES_DEF,
  parameter int NUM_WB_PORTS   = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  t_nuke_pkt              nuke_rb1,
  input  logic                   disp_valid_rs0,
  input  t_disp_pkt              disp_pkt_rs0,
  input  logic [NUM_SOURCES-1:0] src_rdy_rs0,
  output logic                   rs_stall_rs0,
  input  logic [NUM_WB_PORTS-1:0] wb_valid_rs0,
  input  t_prf_id                wb_pdst_rs0 [NUM_WB_PORTS],
  output logic                   iss_valid_rs1,
  output t_disp_pkt              iss_pkt_rs1,
`ifdef RS_PERF_EN
  output logic [$clog2(NUM_RS_ENTRIES):0] perf_occ_rs,
  output logic [31:0]            perf_stall_cyc,
`endif
  input  logic                   ex_ready_rs1
);

  t_rs_entry                 ents [NUM_RS_ENTRIES];
  logic [NUM_RS_ENTRIES-1:0] valid_vec, ready_vec, grant;
  logic [NUM_RS_ENTRIES-1:0] alloc_oh, dealloc_oh;
  logic [NUM_SOURCES-1:0]    ent_hit [NUM_RS_ENTRIES];
  logic [NUM_SOURCES-1:0]    disp_hit;
  logic                      disp_fire, found;

  function automatic logic wb_match(input t_prf_id psrc);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      hit = hit | (wb_valid_rs0[p] && (wb_pdst_rs0[p] == psrc));
    end
    return hit;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      valid_vec[i] = ents[i].valid;
      ready_vec[i] = ents[i].valid && (&ents[i].src_rdy);
      for (int s = 0; s < NUM_SOURCES; s++) begin
        ent_hit[i][s] = wb_match(get_psrc(ents[i].pkt, s));
      end
    end
    for (int s = 0; s < NUM_SOURCES; s++) begin
      disp_hit[s] = wb_match(get_psrc(disp_pkt_rs0, s));
    end
  end

  assign rs_stall_rs0 = &valid_vec;
  assign disp_fire    = disp_valid_rs0 && !rs_stall_rs0 && !nuke_rb1.valid;

  // Free-slot choice looks only at pre-update valids, so a slot freed by an
  // issue this cycle is not reused until the next one.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no latch is inferred.
  always_comb begin
    alloc_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      if (disp_fire && !valid_vec[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  rs_age_matrix #(.N(NUM_RS_ENTRIES)) u_age (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (nuke_rb1.valid),
    .alloc   (alloc_oh),
    .dealloc (dealloc_oh),
    .req     (ready_vec),
    .oldest  (grant)
  );

  // grant is one-hot or zero, so an OR-mux yields '0 when nothing issues.
  always_comb begin
    iss_pkt_rs1 = '0;
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      if (grant[i]) iss_pkt_rs1 = iss_pkt_rs1 | ents[i].pkt;
    end
  end

  assign iss_valid_rs1 = |ready_vec;
  assign dealloc_oh    = (iss_valid_rs1 && ex_ready_rs1) ? grant : '0;

  // NOTE: only the valid bits are reset; payload and src_rdy of a free slot
  // are don't-care and are rewritten on allocation.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      if (!reset_n || nuke_rb1.valid) begin
        ents[i].valid <= 1'b0;
      end else if (alloc_oh[i]) begin
        ents[i].valid   <= 1'b1;
        ents[i].pkt     <= disp_pkt_rs0;
        ents[i].src_rdy <= src_rdy_rs0 | disp_hit;
      end else begin
        if (dealloc_oh[i]) ents[i].valid <= 1'b0;
        ents[i].src_rdy <= ents[i].src_rdy | ent_hit[i];
      end
    end
  end

`ifdef RS_PERF_EN
  always_comb begin
    perf_occ_rs = '0;
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      perf_occ_rs = perf_occ_rs + ($clog2(NUM_RS_ENTRIES)+1)'(valid_vec[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_stall_cyc <= '0;
    end else if (rs_stall_rs0 && (perf_stall_cyc != '1)) begin
      perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`else
  // Performance counters compiled out.
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(disp_valid_rs0 && rs_stall_rs0))
        else $error("rs_sched: dispatch while stalled");
    end
  end
`endif

endmodule

// File: tb/tb_rs_sched.sv
// tb_rs_sched: directed self-checking bench for rs_sched (default build).
module tb_rs_sched;
  import rs_sched_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset_n;
  t_nuke_pkt              nuke;
  logic                   disp_valid;
  t_disp_pkt              disp_pkt;
  logic [NUM_SOURCES-1:0] src_rdy;
  logic                   rs_stall;
  logic [1:0]             wb_valid;
  t_prf_id                wb_pdst [2];
  logic                   iss_valid;
  t_disp_pkt              iss_pkt;
  logic                   ex_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rs_sched #(.NUM_RS_ENTRIES(8), .NUM_WB_PORTS(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .nuke_rb1       (nuke),
    .disp_valid_rs0 (disp_valid),
    .disp_pkt_rs0   (disp_pkt),
    .src_rdy_rs0    (src_rdy),
    .rs_stall_rs0   (rs_stall),
    .wb_valid_rs0   (wb_valid),
    .wb_pdst_rs0    (wb_pdst),
    .iss_valid_rs1  (iss_valid),
    .iss_pkt_rs1    (iss_pkt),
    .ex_ready_rs1   (ex_ready)
  );

  function automatic t_disp_pkt mk(input t_rob_id r, input t_prf_id s1, input t_prf_id s2);
    t_disp_pkt p;
    p              = '0;
    p.uinstr       = 16'hA000 | 16'(r);
    p.robid        = r;
    p.rename.pdst  = t_prf_id'(7'h50 + 7'(r));
    p.rename.psrc1 = s1;
    p.rename.psrc2 = s2;
    p.meta         = 4'h9;
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input t_rob_id r, input t_prf_id s1, input t_prf_id s2,
                          input logic [1:0] rdy);
    disp_valid = 1'b1;
    disp_pkt   = mk(r, s1, s2);
    src_rdy    = rdy;
  endtask

  task automatic idle_disp();
    disp_valid = 1'b0;
    disp_pkt   = '0;
    src_rdy    = '0;
  endtask

  task automatic wake(input logic [1:0] v, input t_prf_id p0, input t_prf_id p1);
    wb_valid   = v;
    wb_pdst[0] = p0;
    wb_pdst[1] = p1;
  endtask

  initial begin
    reset_n  = 1'b0;
    nuke     = '0;
    ex_ready = 1'b0;
    idle_disp();
    wake(2'b00, '0, '0);
    step();
    step();
    check("rst_stall", 64'(rs_stall), 64'd0);
    check("rst_iss_valid", 64'(iss_valid), 64'd0);
    check("rst_iss_pkt", 64'(iss_pkt), 64'd0);
    reset_n = 1'b1;

    // 1: ready uop issues the next cycle and is freed on acceptance.
    ex_ready = 1'b1;
    dispatch(6'h03, 7'h01, 7'h02, 2'b11);
    step();
    idle_disp();
    check("t1_iss_valid", 64'(iss_valid), 64'd1);
    check("t1_iss_pkt", 64'(iss_pkt), 64'(mk(6'h03, 7'h01, 7'h02)));
    step();
    check("t1_freed", 64'(iss_valid), 64'd0);

    // 2: psrc1 woken three cycles after dispatch; issue one cycle later.
    dispatch(6'h05, 7'h12, 7'h13, 2'b10);
    step();
    idle_disp();
    check("t2_wait0", 64'(iss_valid), 64'd0);
    step();
    check("t2_wait1", 64'(iss_valid), 64'd0);
    step();
    check("t2_wait2", 64'(iss_valid), 64'd0);
    wake(2'b01, 7'h12, 7'h00);
    step();
    wake(2'b00, '0, '0);
    check("t2_iss_valid", 64'(iss_valid), 64'd1);
    check("t2_iss_robid", 64'(iss_pkt.robid), 64'h05);
    step();
    check("t2_freed", 64'(iss_valid), 64'd0);

    // 3: back-pressure holds the oldest packet; then in-order drain.
    ex_ready = 1'b0;
    dispatch(6'h01, 7'h01, 7'h01, 2'b11);
    step();
    check("t3_hold_a", 64'(iss_pkt.robid), 64'h01);
    dispatch(6'h02, 7'h01, 7'h01, 2'b11);
    step();
    check("t3_hold_b", 64'(iss_pkt.robid), 64'h01);
    dispatch(6'h03, 7'h01, 7'h01, 2'b11);
    step();
    idle_disp();
    check("t3_hold_c", 64'(iss_pkt.robid), 64'h01);
    step();
    check("t3_hold_d", 64'(iss_pkt.robid), 64'h01);
    check("t3_hold_valid", 64'(iss_valid), 64'd1);
    ex_ready = 1'b1;
    step();
    check("t3_iss_2", 64'(iss_pkt.robid), 64'h02);
    step();
    check("t3_iss_3", 64'(iss_pkt.robid), 64'h03);
    step();
    check("t3_empty", 64'(iss_valid), 64'd0);

    // 4: fill all slots with unready uops (robid 0x10+i in slot i).
    for (int i = 0; i < 8; i++) begin
      dispatch(t_rob_id'(6'h10 + i), t_prf_id'(7'h20 + i), t_prf_id'(7'h30 + i), 2'b00);
      step();
      check($sformatf("t4_fill_stall_%0d", i), 64'(rs_stall), 64'(i == 7));
    end
    idle_disp();
    check("t4_full_noiss", 64'(iss_valid), 64'd0);
    wake(2'b11, 7'h24, 7'h34);
    step();
    wake(2'b00, '0, '0);
    check("t4_wake_robid", 64'(iss_pkt.robid), 64'h14);
    check("t4_still_full", 64'(rs_stall), 64'd1);
    step();
    check("t4_stall_drop", 64'(rs_stall), 64'd0);
    check("t4_no_iss", 64'(iss_valid), 64'd0);
    ex_ready = 1'b0;
    dispatch(6'h1F, 7'h2F, 7'h3F, 2'b11);
    step();
    idle_disp();
    check("t4_refill_stall", 64'(rs_stall), 64'd1);
    check("t4_refill_robid", 64'(iss_pkt.robid), 64'h1F);
    // Slot 7 (robid 0x17) is older than slot 4 (robid 0x1F) despite its index.
    wake(2'b11, 7'h27, 7'h37);
    step();
    wake(2'b00, '0, '0);
    check("t4_age_older", 64'(iss_pkt.robid), 64'h17);
    ex_ready = 1'b1;
    step();
    check("t4_age_next", 64'(iss_pkt.robid), 64'h1F);
    step();
    check("t4_drained", 64'(iss_valid), 64'd0);

    // 5: psrc2 woken in the same cycle it is dispatched.
    dispatch(6'h07, 7'h40, 7'h07, 2'b01);
    wake(2'b11, 7'h55, 7'h07);
    step();
    idle_disp();
    wake(2'b00, '0, '0);
    check("t5_bypass_valid", 64'(iss_valid), 64'd1);
    check("t5_bypass_pkt", 64'(iss_pkt), 64'(mk(6'h07, 7'h40, 7'h07)));
    step();
    check("t5_freed", 64'(iss_valid), 64'd0);

    // 6: drain robid 0x10 leaving five live slots, then nuke with a dispatch.
    wake(2'b11, 7'h20, 7'h30);
    step();
    wake(2'b00, '0, '0);
    check("t6_pre_robid", 64'(iss_pkt.robid), 64'h10);
    step();
    check("t6_pre_idle", 64'(iss_valid), 64'd0);
    nuke.valid = 1'b1;
    dispatch(6'h2A, 7'h01, 7'h01, 2'b11);
    step();
    nuke.valid = 1'b0;
    idle_disp();
    check("t6_nuke_iss", 64'(iss_valid), 64'd0);
    check("t6_nuke_stall", 64'(rs_stall), 64'd0);
    wake(2'b11, 7'h21, 7'h31);
    step();
    wake(2'b00, '0, '0);
    check("t6_nuke_cleared", 64'(iss_valid), 64'd0);

    // 7: reset mid-operation discards a held uop.
    ex_ready = 1'b0;
    dispatch(6'h2B, 7'h01, 7'h01, 2'b11);
    step();
    idle_disp();
    check("t7_pre_robid", 64'(iss_pkt.robid), 64'h2B);
    reset_n = 1'b0;
    step();
    check("t7_rst_iss", 64'(iss_valid), 64'd0);
    check("t7_rst_stall", 64'(rs_stall), 64'd0);
    reset_n = 1'b1;
    step();
    check("t7_post_iss", 64'(iss_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_sched.md
Name: rs_sched

Overview:
- Reservation station at the receiving end of the allocation dispatch interface (disp_valid_rs0 / disp_pkt_rs0 / rs_stall_rs0).
- Buffers dispatched uops and tracks per-source readiness using physical-register writeback wakeups.
- Each cycle, issues the oldest fully-ready uop to the execute pipe over a valid/ready handshake.
- Flushes all contents on a nuke.

Parameters:
NUM_RS_ENTRIES, 8, number of buffered uops (power of two, >=2)
NUM_WB_PORTS, 2, number of writeback wakeup broadcast ports

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
nuke_rb1  in  t_nuke_pkt  flush request; .valid clears all entries
disp_valid_rs0  in  1  dispatch valid; only asserted while rs_stall_rs0 is low
disp_pkt_rs0  in  t_disp_pkt  dispatched uop: uinstr, robid, rename (pdst/psrc1/psrc2), meta
src_rdy_rs0  in  NUM_SOURCES  per-source ready flags from the rename scoreboard at dispatch
rs_stall_rs0  out  1  RS cannot accept a dispatch this cycle
wb_valid_rs0  in  NUM_WB_PORTS  wakeup broadcast valid
wb_pdst_rs0  in  NUM_WB_PORTS x t_prf_id  physical register being written
iss_valid_rs1  out  1  issue packet valid
iss_pkt_rs1  out  t_disp_pkt  issued uop
ex_ready_rs1  in  1  execute accepts the issue this cycle

Behaviour:
- Reset (reset_n==0 at posedge): all entry valids cleared; rs_stall_rs0=0; iss_valid_rs1=0; iss_pkt_rs1 driven '0.
- Entry state: valid, t_disp_pkt, src_rdy[NUM_SOURCES], plus an age matrix row (NUM_RS_ENTRIES bits).
- rs_stall_rs0 is a function of registered state only, with no combinational path from disp_valid_rs0: it is high iff no entry is free.
- A dispatch arriving while stalled is an assertion failure.
- Dispatch: disp_valid_rs0 writes the lowest-index free entry at the posedge.
  - Its src_rdy = src_rdy_rs0 OR a same-cycle match of psrc against any valid wb_pdst_rs0.
  - Sources with no register operand are marked ready by the scoreboard.
  - The new entry's age row marks all currently valid entries as older.
- Wakeup: for each valid entry, a source whose psrc equals any valid wb_pdst_rs0 sets src_rdy at the posedge.
- Select: an entry is ready when valid and all src_rdy are set.
  - Pick the ready entry with no older ready entry (age matrix); oldest-first regardless of robid wrap.
  - iss_valid_rs1/iss_pkt_rs1 are combinational from registered state.
- Issue handshake: the entry is deallocated at the posedge where iss_valid_rs1 & ex_ready_rs1.
  - If ex_ready_rs1 is low, the same packet is held (or replaced by an older one that became ready).
- Latency: a uop dispatched with all sources ready in cycle N issues earliest in N+1; a wakeup in cycle N makes the entry issuable in N+1.
- Simultaneous issue-dealloc and dispatch in the same cycle:
  - Both take effect.
  - The freed entry is not reused until the next cycle, because the free-slot choice uses pre-update valids.
  - A full RS therefore accepts a new dispatch one cycle after an issue.
- Nuke: nuke_rb1.valid clears all entry valids at the posedge.
  - A same-cycle dispatch is dropped.
  - A same-cycle issue is still presented; no downstream guarantee is given, and execute must squash it.
- Reset mid-operation: everything is discarded; no issue occurs in the reset cycle.

Optional Feature:
RS_PERF_EN:
- Defined: adds outputs perf_occ_rs (clog2(NUM_RS_ENTRIES)+1 bits, live count of valid entries) and perf_stall_cyc (32-bit saturating counter of cycles with rs_stall_rs0 high). Both are cleared by reset and nuke (occupancy only).
- Undefined: the ports and counters are absent.

Decomposition:
- Shared package: t_rs_entry (valid, disp pkt, src_rdy), t_rs_id, and the NUM_RS_ENTRIES default constant.
- Uses existing t_disp_pkt, t_prf_id, t_nuke_pkt, NUM_SOURCES.
- One natural sub-module: rs_age_matrix. It takes alloc-one-hot, dealloc-one-hot, flush, and request vector as inputs, and returns the oldest-request one-hot.

Test Plan:
- Dispatch robid 0x3 with src_rdy=2'b11, ex_ready_rs1=1 -> iss_valid_rs1 next cycle with robid 0x3; entry freed.
- Dispatch robid 0x5 with psrc1=0x12 not ready; wb_pdst=0x12 three cycles later -> issue exactly one cycle after the wakeup.
- Dispatch robids 0x1, 0x2, 0x3 all ready, ex_ready_rs1 held low for 4 cycles -> iss_pkt_rs1 holds 0x1; then issues in order 0x1, 0x2, 0x3.
- Fill 8 entries with unready sources -> rs_stall_rs0=1; wake and issue one -> rs_stall_rs0 drops the following cycle; a new dispatch is accepted.
- Dispatch with psrc2=0x7 in the same cycle as wb_pdst=0x7 -> entry captured ready; issues next cycle.
- Nuke with 5 valid entries plus a concurrent dispatch -> all entries cleared; iss_valid_rs1=0 next cycle; rs_stall_rs0=0.
